// File: rtl/register_pkg.sv
// Shared datapath constants: default data width and reset value for storage registers.
package register_pkg;

  localparam int DATA_WIDTH = 8;
  localparam logic [DATA_WIDTH-1:0] RESET_VALUE_DEF = '0;

endpackage

// File: rtl/register_if.sv
// Register bus: load strobe, data in, output enable and the shared tri-state read-back bus.
interface register_if
  import register_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
);

  logic [WIDTH-1:0] data;
  logic             latch;
  logic             enable;
  // Net, not variable: several registers may drive this bus, each releasing it with Z.
  wire  [WIDTH-1:0] reg_out;

  modport master (
    output data,
    output latch,
    output enable,
    input  reg_out
  );

  modport slave (
    input  data,
    input  latch,
    input  enable,
    output reg_out
  );

endinterface

// File: rtl/register.sv
// Datapath storage register: loads on clk when latch=1, drives the shared bus only while enable=1.
module register
  import register_pkg::*;
#(
  parameter int               WIDTH       = DATA_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(RESET_VALUE_DEF)
) (
  input  logic     clk,
  input  logic     reset,
  register_if.slave bus
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= RESET_VALUE;
    end else if (bus.latch) begin
      r_q <= bus.data;
    end
  end

  // No bypass from data: the bus always reflects the stored value, never the pending load.
  assign bus.reg_out = bus.enable ? r_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_register.sv
// Scoreboard bench for register: expected bus values queued with each stimulus step, compared once settled.
module tb_register;

  logic clk;
  logic reset;

  register_if #(.WIDTH(8)) bus ();

  register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire w_hiz = (bus.reg_out === 8'hzz);

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got {hiz,val}=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic hiz, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.exp = {hiz, val};
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t       e;
    logic [8:0] obs;
    e   = sb_q.pop_front();
    obs = {w_hiz, (w_hiz ? 8'h00 : bus.reg_out)};
    check_val(e.tag, obs, e.exp);
  endtask

  // Queue the expectation, let the combinational path settle, then score it.
  task automatic exp_chk(input string tag, input logic hiz, input logic [7:0] val);
    expect_out(tag, hiz, val);
    #1;
    compare_out();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] hold_pat [5];

  initial begin
    hold_pat[0] = 8'h12;
    hold_pat[1] = 8'h34;
    hold_pat[2] = 8'hFF;
    hold_pat[3] = 8'h12;
    hold_pat[4] = 8'h34;

    reset      = 1'b0;
    bus.latch  = 1'b1;
    bus.data   = 8'hFF;
    bus.enable = 1'b1;

    // Reset dominates latch across several edges
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_chk("rst_hold", 1'b0, 8'h00);
    end
    @(negedge clk);
    bus.enable = 1'b0;
    exp_chk("rst_disabled_z", 1'b1, 8'h00);

    // Load then enable
    reset     = 1'b1;
    bus.data  = 8'hAA;
    bus.latch = 1'b1;
    tick();
    @(negedge clk);
    bus.latch  = 1'b0;
    bus.enable = 1'b1;
    exp_chk("load_aa", 1'b0, 8'hAA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.data = 8'($urandom);
      tick();
      exp_chk("hold_aa", 1'b0, 8'hAA);
    end

    // Reload while enabled: old value until the edge
    @(negedge clk);
    bus.data  = 8'h55;
    bus.latch = 1'b1;
    exp_chk("no_bypass", 1'b0, 8'hAA);
    tick();
    exp_chk("reload_55", 1'b0, 8'h55);
    @(negedge clk);
    bus.latch = 1'b0;

    // Enable gates the bus only
    bus.enable = 1'b0;
    exp_chk("disable_z", 1'b1, 8'h00);
    tick();
    @(negedge clk);
    bus.enable = 1'b1;
    exp_chk("reenable_55", 1'b0, 8'h55);

    // Asynchronous reset between edges
    tick();
    #1;
    reset = 1'b0;
    exp_chk("async_rst", 1'b0, 8'h00);
    reset = 1'b1;
    exp_chk("async_rst_release", 1'b0, 8'h00);

    // First edge after release loads normally
    @(negedge clk);
    bus.data  = 8'h3C;
    bus.latch = 1'b1;
    tick();
    exp_chk("first_load", 1'b0, 8'h3C);
    @(negedge clk);
    bus.latch = 1'b0;

    // data activity without latch has no effect
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.data = hold_pat[i];
      tick();
      exp_chk("no_latch_hold", 1'b0, 8'h3C);
    end

    // Reset while disabled: bus stays Z, stored value cleared
    @(negedge clk);
    bus.enable = 1'b0;
    reset      = 1'b0;
    exp_chk("rst_while_off_z", 1'b1, 8'h00);
    bus.enable = 1'b1;
    exp_chk("rst_while_off_val", 1'b0, 8'h00);
    reset = 1'b1;

    // All-ones load exercises every bit
    @(negedge clk);
    bus.data  = 8'hFF;
    bus.latch = 1'b1;
    tick();
    exp_chk("load_ff", 1'b0, 8'hFF);
    @(negedge clk);
    bus.latch = 1'b0;
    tick();

    check_val("sb_drain", 9'(sb_q.size()), 9'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/register.md
Name: register

Overview:
- General-purpose clocked storage register with a load strobe (`latch`) and an output enable (`enable`).
- It is the basic storage element of the CPU datapath and is instantiated for the accumulator, operand and similar registers.
- Output is tri-state, so several instances can share one data bus.

Parameters:
- WIDTH, 8, data width in bits of `data`, the stored value and `reg_out`.
- RESET_VALUE, 0, value loaded into the storage element on reset; WIDTH bits wide.

Ports:
- clk  input  1  system clock; all loads occur on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears the stored value to RESET_VALUE.
- data  input  WIDTH  value to be stored.
- latch  input  1  load strobe, active-high; sampled on the rising edge of `clk`.
- enable  input  1  output enable, active-high.
- reg_out  output  WIDTH  stored value when `enable`=1; high-impedance (all bits Z) when `enable`=0.

Behaviour:
- Storage element: one internal WIDTH-bit register `q`.
- Reset:
  - `reset`=0 forces `q`=RESET_VALUE immediately, independent of `clk`.
  - Reset has priority over `latch`.
  - While `reset` is low, `q` holds RESET_VALUE and ignores all clock edges.
- Load:
  - On a rising `clk` edge with `reset`=1 and `latch`=1, `q` takes `data`.
  - Latency is 1 edge: the new value is visible on `reg_out` (if enabled) right after that edge.
- Hold: on a rising edge with `latch`=0, `q` is unchanged.
  - There is no other way to modify `q`.
- Output:
  - `reg_out` is purely combinational from `q` and `enable`: `reg_out` = `enable` ? `q` : Z.
  - There is no clock delay on `enable`.
  - `enable` never affects `q`.
- No bypass:
  - While `latch`=1 and `enable`=1 before the edge, `reg_out` shows the old `q`, not `data`.
  - `reg_out` shows the new `q` only after the edge.
- Reset while enabled: `reg_out` shows RESET_VALUE immediately, without waiting for a clock edge.
- Reset deassertion:
  - Takes effect asynchronously.
  - A `latch`=1 on the first rising edge after deassertion loads normally.
- `data` may change freely except around the sampling edge; changes while `latch`=0 have no effect.
- Widths: no arithmetic; `data`, `q` and `reg_out` are all WIDTH bits, with no truncation or extension.
- No state machine; the block holds a single state.
- After reset, `q` holds RESET_VALUE and `reg_out` is Z unless `enable`=1.

Decomposition:
- Shared package: a data-width constant of 8, used as the default for WIDTH across datapath blocks.
- Shared package: a reset-value constant of 0.
- Sub-modules: none; the block is a single flat module containing one storage process and one tri-state output assignment.

Test Plan:
- Reset: hold `reset`=0 across several edges with `latch`=1, `data`=0xFF and `enable`=1 → `reg_out`=0x00 throughout; `reg_out`=Z once `enable`=0.
- Load then enable: set `data`=0xAA and `latch`=1 for one rising edge, then `latch`=0 and `enable`=1 → `reg_out`=0xAA; it stays 0xAA over later edges while `data` changes.
- Reload while enabled: with `enable`=1 and `q`=0xAA, set `data`=0x55 and `latch`=1 → `reg_out`=0xAA before the edge and 0x55 after it.
- Disable: set `enable`=0 with `q`=0x55 → `reg_out`=Z. Then set `enable`=1 with no load → `reg_out`=0x55, confirming that `enable` does not change `q`.
- Asynchronous reset mid-operation: with `q`=0x55 and `enable`=1, pulse `reset` low between clock edges → `reg_out`=0x00 immediately, before the next edge.
- No-latch hold: hold `latch`=0 and toggle `data` through 0x12, 0x34 and 0xFF over 5 edges → `reg_out` unchanged.
